// File: rtl/rs_station_ooo_pkg.sv
// Shared definitions for the out-of-order reservation station slice:
// default widths, op-class encodings and broadcast channel indices.
package rs_station_ooo_pkg;

    localparam int DEPTH_DEF   = 16;
    localparam int DATA_W_DEF  = 32;
    localparam int TAG_W_DEF   = 4;
    localparam int OP_W_DEF    = 6;
    localparam int NUM_CDB_DEF = 3;

    // Broadcast channel indices on the packed cdb_* buses.
    localparam int CDB_ALU  = 0;
    localparam int CDB_LOAD = 1;
    localparam int CDB_ROB  = 2;

    // Op classes that this execution port understands.
    typedef enum logic [OP_W_DEF-1:0] {
        OPC_ALU     = 6'd0,
        OPC_ALU_IMM = 6'd1,
        OPC_BRANCH  = 6'd2,
        OPC_JAL     = 6'd3,
        OPC_JALR    = 6'd4,
        OPC_LUI     = 6'd5,
        OPC_AUIPC   = 6'd6
    } opClass_e;

endpackage

// File: rtl/rs_station_ooo_age.sv
// Age matrix: tracks relative allocation order of station entries and
// picks the oldest entry among a ready vector.
module rs_age_matrix #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DEPTH-1:0] allocOh,
    input  logic [DEPTH-1:0] deallocOh,
    input  logic [DEPTH-1:0] readyVec,
    output logic [DEPTH-1:0] oldestOh
);

    // older_q[i][j] set means entry j was allocated before entry i and is still live.
    logic [DEPTH-1:0] older_q [DEPTH];

    // A new entry marks every other slot as older; free slots never block because
    // they are never ready, and their column is wiped when they are reallocated.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (allocOh[i]) begin
                        older_q[i][j] <= (j != i);
                    end else if (allocOh[j] || deallocOh[j]) begin
                        older_q[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // An entry is the oldest ready one when no ready entry is older than it.
    always_comb begin
        oldestOh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            oldestOh[i] = readyVec[i] & ~(|(older_q[i] & readyVec));
        end
    end

endmodule

// File: rtl/rs_station_ooo.sv
// Tomasulo reservation station for one ALU/branch port: dispatch allocation
// with CDB bypass, tag wakeup, oldest-ready select and a registered issue stage.
module rs_station_ooo
    import rs_station_ooo_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int NUM_CDB = NUM_CDB_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [OP_W-1:0]           alloc_op,
    input  logic [DATA_W-1:0]         alloc_vj,
    input  logic [DATA_W-1:0]         alloc_vk,
    input  logic                      alloc_qj_v,
    input  logic                      alloc_qk_v,
    input  logic [TAG_W-1:0]          alloc_qj,
    input  logic [TAG_W-1:0]          alloc_qk,
    input  logic [DATA_W-1:0]         alloc_imm,
    input  logic [DATA_W-1:0]         alloc_pc,
    input  logic [TAG_W-1:0]          alloc_tag,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [OP_W-1:0]           issue_op,
    output logic [DATA_W-1:0]         issue_vj,
    output logic [DATA_W-1:0]         issue_vk,
    output logic [DATA_W-1:0]         issue_imm,
    output logic [DATA_W-1:0]         issue_pc,
    output logic [TAG_W-1:0]          issue_tag,
    output logic [$clog2(DEPTH):0]    free_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]  busy_q, qjV_q, qkV_q;
    logic [OP_W-1:0]   op_q  [DEPTH];
    logic [DATA_W-1:0] vj_q  [DEPTH];
    logic [DATA_W-1:0] vk_q  [DEPTH];
    logic [DATA_W-1:0] imm_q [DEPTH];
    logic [DATA_W-1:0] pc_q  [DEPTH];
    logic [TAG_W-1:0]  qj_q  [DEPTH];
    logic [TAG_W-1:0]  qk_q  [DEPTH];
    logic [TAG_W-1:0]  tag_q [DEPTH];

    logic              issueValid_q;
    logic [OP_W-1:0]   issueOp_q;
    logic [DATA_W-1:0] issueVj_q, issueVk_q, issueImm_q, issuePc_q;
    logic [TAG_W-1:0]  issueTag_q;
    logic [CNT_W-1:0]  freeCount_q, freeCount_d;

    logic [DEPTH-1:0]  readyVec, oldestOh, allocOh, deallocOh;
    logic [IDX_W-1:0]  allocIdx, selIdx;
    logic              allocFire, loadOut;
    logic [DATA_W:0]   snoopJ [DEPTH];
    logic [DATA_W:0]   snoopK [DEPTH];
    logic [DATA_W:0]   bypJ, bypK;

    // Returns {hit, value}; scanning high to low lets the lowest matching channel win.
    function automatic logic [DATA_W:0] snoop(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, data[c*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    assign alloc_ready = |(~busy_q);
    assign readyVec    = busy_q & ~qjV_q & ~qkV_q;

    // Lowest free slot takes the new op; handshakes only fire in an enabled, unflushed cycle.
    always_comb begin
        allocIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) allocIdx = IDX_W'(i);
        end
        allocFire = rdy & ~flush & alloc_valid & alloc_ready;
        allocOh   = '0;
        if (allocFire) allocOh[allocIdx] = 1'b1;
        selIdx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (oldestOh[i]) selIdx = IDX_W'(i);
        end
        loadOut     = rdy & ~flush & (~issueValid_q | issue_ready) & (|readyVec);
        deallocOh   = loadOut ? oldestOh : '0;
        freeCount_d = freeCount_q - CNT_W'(allocFire) + CNT_W'(loadOut);
    end

    // Tag matches against this cycle's broadcasts, for stored entries and for the incoming op.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snoopJ[i] = snoop(qj_q[i], cdb_valid, cdb_tag, cdb_data);
            snoopK[i] = snoop(qk_q[i], cdb_valid, cdb_tag, cdb_data);
        end
        bypJ = snoop(alloc_qj, cdb_valid, cdb_tag, cdb_data);
        bypK = snoop(alloc_qk, cdb_valid, cdb_tag, cdb_data);
    end

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk      (clk),
        .rst      (rst),
        .clear    (rdy & flush),
        .allocOh  (allocOh),
        .deallocOh(deallocOh),
        .readyVec (readyVec),
        .oldestOh (oldestOh)
    );

    // Entry array, wakeup, issue register and free counter; rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            qjV_q        <= '0;
            qkV_q        <= '0;
            issueValid_q <= 1'b0;
            issueOp_q    <= '0;
            issueVj_q    <= '0;
            issueVk_q    <= '0;
            issueImm_q   <= '0;
            issuePc_q    <= '0;
            issueTag_q   <= '0;
            freeCount_q  <= CNT_W'(DEPTH);
        end else if (rdy) begin
            if (flush) begin
                busy_q       <= '0;
                issueValid_q <= 1'b0;
                freeCount_q  <= CNT_W'(DEPTH);
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (allocOh[i]) begin
                        busy_q[i] <= 1'b1;
                        op_q[i]   <= alloc_op;
                        imm_q[i]  <= alloc_imm;
                        pc_q[i]   <= alloc_pc;
                        tag_q[i]  <= alloc_tag;
                        qj_q[i]   <= alloc_qj;
                        qk_q[i]   <= alloc_qk;
                        qjV_q[i]  <= alloc_qj_v & ~bypJ[DATA_W];
                        qkV_q[i]  <= alloc_qk_v & ~bypK[DATA_W];
                        vj_q[i]   <= (alloc_qj_v && bypJ[DATA_W]) ? bypJ[DATA_W-1:0] : alloc_vj;
                        vk_q[i]   <= (alloc_qk_v && bypK[DATA_W]) ? bypK[DATA_W-1:0] : alloc_vk;
                    end else if (busy_q[i]) begin
                        if (qjV_q[i] && snoopJ[i][DATA_W]) begin
                            qjV_q[i] <= 1'b0;
                            vj_q[i]  <= snoopJ[i][DATA_W-1:0];
                        end
                        if (qkV_q[i] && snoopK[i][DATA_W]) begin
                            qkV_q[i] <= 1'b0;
                            vk_q[i]  <= snoopK[i][DATA_W-1:0];
                        end
                        if (deallocOh[i]) busy_q[i] <= 1'b0;
                    end
                end
                if (loadOut) begin
                    issueValid_q <= 1'b1;
                    issueOp_q    <= op_q[selIdx];
                    issueVj_q    <= vj_q[selIdx];
                    issueVk_q    <= vk_q[selIdx];
                    issueImm_q   <= imm_q[selIdx];
                    issuePc_q    <= pc_q[selIdx];
                    issueTag_q   <= tag_q[selIdx];
                end else if (issue_ready) begin
                    issueValid_q <= 1'b0;
                end
                freeCount_q <= freeCount_d;
            end
        end
    end

    assign issue_valid = issueValid_q;
    assign issue_op    = issueOp_q;
    assign issue_vj    = issueVj_q;
    assign issue_vk    = issueVk_q;
    assign issue_imm   = issueImm_q;
    assign issue_pc    = issuePc_q;
    assign issue_tag   = issueTag_q;
    assign free_count  = freeCount_q;

endmodule
